// File: rtl/sensor_capture_bank_pkg.sv
// rtl/sensor_capture_bank_pkg.sv - shared encodings for the sensor capture bank
package sensor_capture_bank_pkg;

  localparam int HIT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMING  = 2'd1,
    ST_PRESSED = 2'd2
  } ch_state_t;

  typedef enum logic [1:0] {
    RD_RAW      = 2'd0,
    RD_FLAG     = 2'd1,
    RD_COUNT    = 2'd2,
    RD_FLAG_CLR = 2'd3
  } rd_mode_t;

  function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sensor_capture_bank_if.sv
// rtl/sensor_capture_bank_if.sv - read request/response bus of the sensor capture bank
interface sensor_capture_bank_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
);
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [1:0]        rd_mode;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_en, rd_idx, rd_mode, input rd_valid, rd_data);
  modport slave  (input rd_en, rd_idx, rd_mode, output rd_valid, rd_data);
endinterface

// File: rtl/sensor_capture_bank_channel_fsm.sv
// rtl/sensor_capture_bank_channel_fsm.sv - per-channel debounce FSM with sticky hit flag and hit count
module sensor_channel_fsm
  import sensor_capture_bank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEBOUNCE = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_W-1:0]    i_snapshot,
  input  logic [DATA_W-1:0]    i_threshold,
  input  logic                 i_clr,
  output logic                 o_flag,
  output logic [HIT_CNT_W-1:0] o_count
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  ch_state_t            r_state;
  logic [3:0]           r_cnt;
  logic                 r_flag;
  logic [HIT_CNT_W-1:0] r_count;

  logic       w_ge;
  logic [3:0] w_cnt_nxt;
  logic       w_hit;

  assign w_ge      = i_snapshot >= i_threshold;
  assign w_cnt_nxt = r_cnt + 4'd1;
  // A hit is the single transition into PRESSED; DEBOUNCE=1 jumps straight from IDLE.
  assign w_hit = w_ge && (((r_state == ST_IDLE) && (DEB == 4'd1)) ||
                          ((r_state == ST_ARMING) && (w_cnt_nxt == DEB)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_flag  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_state <= ST_PRESSED;
            r_cnt   <= DEB;
          end else if (w_ge) begin
            r_state <= ST_ARMING;
            r_cnt   <= 4'd1;
          end else begin
            r_cnt   <= 4'd0;
          end
        end
        ST_ARMING: begin
          if (!w_ge) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_hit) r_state <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (!w_ge) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
      // A new hit outranks a same-cycle clear.
      if (w_hit) begin
        r_flag  <= 1'b1;
        r_count <= sat_inc(r_count);
      end else if (i_clr) begin
        r_flag  <= 1'b0;
      end
    end
  end

  assign o_flag  = r_flag;
  assign o_count = r_count;

endmodule

// File: rtl/sensor_capture_bank.sv
// rtl/sensor_capture_bank.sv - top: snapshot registers, channel array and registered read mux
module sensor_capture_bank
  import sensor_capture_bank_pkg::*;
#(
  parameter int NUM_CH   = 9,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] sensor_readings,
  input  logic [DATA_W-1:0]        threshold,
  sensor_capture_bank_if.slave     rd_bus,
  output logic [NUM_CH-1:0]        hit_mask,
  output logic                     any_hit
);

  logic [DATA_W-1:0]    r_snap [NUM_CH];
  logic                 r_rd_valid;
  logic [DATA_W-1:0]    r_rd_data;

  logic [HIT_CNT_W-1:0] w_count [NUM_CH];
  logic [NUM_CH-1:0]    w_clr;
  logic [DATA_W-1:0]    w_sel_snap;
  logic                 w_sel_flag;
  logic [HIT_CNT_W-1:0] w_sel_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) r_snap[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) r_snap[k] <= sensor_readings[k*DATA_W +: DATA_W];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_clr[g] = rd_bus.rd_en && (rd_bus.rd_mode == RD_FLAG_CLR) &&
                      (rd_bus.rd_idx == IDX_W'(g));

    sensor_channel_fsm #(
      .DATA_W   (DATA_W),
      .DEBOUNCE (DEBOUNCE)
    ) u_ch (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_snapshot  (r_snap[g]),
      .i_threshold (threshold),
      .i_clr       (w_clr[g]),
      .o_flag      (hit_mask[g]),
      .o_count     (w_count[g])
    );
  end

  assign any_hit = |hit_mask;

  // Out-of-range indices match no channel, so every selection falls back to zero.
  always_comb begin
    w_sel_snap  = '0;
    w_sel_flag  = 1'b0;
    w_sel_count = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_bus.rd_idx == IDX_W'(k)) begin
        w_sel_snap  = r_snap[k];
        w_sel_flag  = hit_mask[k];
        w_sel_count = w_count[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (rd_bus.rd_en) begin
      r_rd_valid <= 1'b1;
      case (rd_bus.rd_mode)
        RD_RAW:   r_rd_data <= w_sel_snap;
        RD_COUNT: r_rd_data <= DATA_W'(w_sel_count);
        default:  r_rd_data <= DATA_W'(w_sel_flag);
      endcase
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_bus.rd_valid = r_rd_valid;
  assign rd_bus.rd_data  = r_rd_data;

endmodule
